// File: rtl/dht11_responder.sv
// Sensor end of the DHT11 single-wire link: qualifies the host start pulse, then plays back
// ack + 40-bit frame (data MSB first, checksum last) as open-drain low drive.
module dht11_responder #(
  parameter int T_START_MIN = 18000,
  parameter int T_RESP_DLY  = 30,
  parameter int T_ACK_LOW   = 80,
  parameter int T_ACK_HIGH  = 80,
  parameter int T_BIT_LOW   = 50,
  parameter int T_ZERO_HIGH = 26,
  parameter int T_ONE_HIGH  = 70,
  parameter int T_END_LOW   = 50,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dht_in,
  input  logic [31:0] frame_data,
  output logic        dht_drive_low,
  output logic        busy,
  output logic        start_seen,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE, MEAS_LOW, RESP_DLY, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  localparam logic [CNT_W-1:0] L_START = CNT_W'(T_START_MIN);
  localparam logic [CNT_W-1:0] L_RESP  = CNT_W'(T_RESP_DLY);
  localparam logic [CNT_W-1:0] L_ACKL  = CNT_W'(T_ACK_LOW);
  localparam logic [CNT_W-1:0] L_ACKH  = CNT_W'(T_ACK_HIGH);
  localparam logic [CNT_W-1:0] L_BITL  = CNT_W'(T_BIT_LOW);
  localparam logic [CNT_W-1:0] L_ZERO  = CNT_W'(T_ZERO_HIGH);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(T_ONE_HIGH);
  localparam logic [CNT_W-1:0] L_ENDL  = CNT_W'(T_END_LOW);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt, phase_len;
  logic [5:0]       bit_idx, nxt_bit;
  logic [39:0]      shift;
  logic [7:0]       csum;
  logic             sync1, line, armed;
  logic             accept, done, phase_last;

  assign csum = frame_data[31:24] + frame_data[23:16] + frame_data[15:8] + frame_data[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      sync1      <= 1'b0;
      line       <= 1'b0;
      armed      <= 1'b0;
      start_seen <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      bit_idx    <= nxt_bit;
      sync1      <= dht_in;
      line       <= sync1;
      start_seen <= accept;
      frame_done <= done;
      if (accept) shift <= {frame_data, csum};
      // A line still low at frame end must go high before it can count as a new request
      if (done)      armed <= 1'b0;
      else if (line) armed <= 1'b1;
    end
  end

  always_comb begin
    phase_len = L_RESP;
    case (state)
      ACK_LOW:  phase_len = L_ACKL;
      ACK_HIGH: phase_len = L_ACKH;
      BIT_LOW:  phase_len = L_BITL;
      BIT_HIGH: phase_len = shift[bit_idx] ? L_ONE : L_ZERO;
      END_LOW:  phase_len = L_ENDL;
      default:  phase_len = L_RESP;
    endcase
  end

  assign phase_last = (cnt == phase_len - 1'b1);

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_bit   = bit_idx;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (!line && armed) begin
          nxt_state = MEAS_LOW;
          nxt_cnt   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      MEAS_LOW: begin
        if (!line) begin
          if (cnt != '1) nxt_cnt = cnt + 1'b1;
        end else begin
          nxt_cnt = '0;
          if (cnt >= L_START) begin
            nxt_state = RESP_DLY;
            accept    = 1'b1;
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      default: begin
        nxt_cnt = phase_last ? '0 : cnt + 1'b1;
        if (phase_last) begin
          case (state)
            RESP_DLY: nxt_state = ACK_LOW;
            ACK_LOW:  nxt_state = ACK_HIGH;
            ACK_HIGH: begin
              nxt_state = BIT_LOW;
              nxt_bit   = 6'd39;
            end
            BIT_LOW:  nxt_state = BIT_HIGH;
            BIT_HIGH: begin
              if (bit_idx == 6'd0) nxt_state = END_LOW;
              else begin
                nxt_state = BIT_LOW;
                nxt_bit   = bit_idx - 6'd1;
              end
            end
            default: begin
              nxt_state = IDLE;
              done      = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    dht_drive_low = (state == ACK_LOW) || (state == BIT_LOW) || (state == END_LOW);
    busy          = (state != IDLE) && (state != MEAS_LOW);
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: host pulses on a wired-AND line, frames compared as run-length
// segments against a waveform built directly from the protocol timing table.
module tb_dht11_responder;

  localparam int T_START = 1000;

  logic        clk, rst, host_low;
  logic [31:0] frame_data;
  logic        dht_in, dht_drive_low, busy, start_seen, frame_done;
  int          checks, errors;

  assign dht_in = ~(host_low | dht_drive_low);

  dht11_responder #(.T_START_MIN(T_START)) dut (
    .clk(clk), .rst(rst), .dht_in(dht_in), .frame_data(frame_data),
    .dht_drive_low(dht_drive_low), .busy(busy), .start_seen(start_seen), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic host_start(input int n);
    @(posedge clk); #1 host_low = 1'b1;
    repeat (n) @(posedge clk);
    #1 host_low = 1'b0;
  endtask

  // Expected line-drive waveform: alternating released/low run lengths, starting released.
  task automatic build_segs(input logic [31:0] d, output int segs[$]);
    logic [39:0] word;
    logic [7:0]  ck;
    ck   = 8'((int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0])) % 256);
    word = {d, ck};
    segs = {};
    segs.push_back(30); segs.push_back(80); segs.push_back(80);
    for (int b = 39; b >= 0; b--) begin
      segs.push_back(50);
      segs.push_back(word[b] ? 70 : 26);
    end
    segs.push_back(50);
  endtask

  // mode 0: plain, 1: change frame_data mid-frame, 2: reset at bit 12, 3: host grabs line during end low
  task automatic run_frame(input int hold, input int mode);
    logic [31:0] d;
    int segs[$];
    int obs[$];
    int n, total, rst_pt, busy_bad, run, m;
    bit got, done, lvl;
    d = frame_data;
    build_segs(d, segs);
    total = 0;
    foreach (segs[i]) total += segs[i];
    rst_pt = 190 + 10;
    for (int i = 0; i < 12; i++) rst_pt += segs[3 + 2*i] + segs[4 + 2*i];
    host_start(hold);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (start_seen) got = 1;
    end
    check("start_seen", int'(got), 1);
    if (!got) return;
    n = 0; busy_bad = 0; done = 0; lvl = 0; run = 0;
    while (!done && n < 12000) begin
      if (mode == 2 && n == rst_pt) begin
        check("pre_rst_drive", int'(dht_drive_low), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_drive", int'(dht_drive_low), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk) rst = 1'b0;
        return;
      end
      if (mode == 1 && n == 300) frame_data = ~d;
      if (mode == 3 && n == total - 20) host_low = 1'b1;
      if (!busy) busy_bad++;
      if (dht_drive_low == lvl) run++;
      else begin
        obs.push_back(run);
        lvl = ~lvl;
        run = 1;
      end
      n++;
      @(negedge clk);
      if (frame_done) done = 1;
    end
    obs.push_back(run);
    check("frame_done", int'(done), 1);
    check("busy_after", int'(busy), 0);
    check("drive_after", int'(dht_drive_low), 0);
    check("busy_during", busy_bad, 0);
    check("nsegs", obs.size(), segs.size());
    m = (obs.size() < segs.size()) ? obs.size() : segs.size();
    for (int i = 0; i < m; i++) check($sformatf("seg%0d", i), obs[i], segs[i]);
  endtask

  initial begin
    int ss, dl;
    checks = 0; errors = 0;
    rst = 1'b1; host_low = 1'b0; frame_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_drive_low", int'(dht_drive_low), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_start_seen", int'(start_seen), 0);
    check("rst_frame_done", int'(frame_done), 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);

    frame_data = 32'h3C00_1900;
    run_frame(T_START, 0);

    // one tick short of the threshold: ignored
    host_start(T_START - 1);
    ss = 0; dl = 0;
    repeat (60) begin
      @(negedge clk);
      ss += int'(start_seen);
      dl += int'(dht_drive_low);
    end
    check("short_start_seen", ss, 0);
    check("short_drive", dl, 0);

    frame_data = 32'hFFFF_0102;
    run_frame(T_START, 0);

    frame_data = $urandom;
    run_frame(T_START, 2);
    repeat (5) @(posedge clk);
    frame_data = $urandom;
    run_frame(T_START + 3, 0);

    frame_data = $urandom;
    run_frame(T_START, 1);

    // line held low across frame end, longer than a valid start, must not retrigger
    frame_data = $urandom;
    run_frame(T_START, 3);
    ss = 0;
    repeat (T_START + 200) begin
      @(negedge clk);
      ss += int'(start_seen);
    end
    host_low = 1'b0;
    repeat (5) @(negedge clk) ss += int'(start_seen);
    check("held_low_no_start", ss, 0);
    frame_data = $urandom;
    run_frame(T_START, 0);

    for (int k = 0; k < 2; k++) begin
      frame_data = $urandom;
      run_frame(T_START + int'($urandom_range(0, 300)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
